regs_scoreboard: RTL and testbench

//   Architectural integer register file and the write end of the WB-stage register-write interface.
//   - Writes: accepts the registered writeback triple (data, waddr, we) from the WB stage.
//   - Reads: serves two ID-stage read ports, with same-cycle write-through bypass.
//   - Hazards: keeps a per-register pending-write scoreboard. ID stalls on RAW hazards not yet resolved by writeback.

---
 rtl/regs_scoreboard.sv | 106 ++++++++++
 tb/tb_regs_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regs_scoreboard.sv
// Architectural integer register file with two write-through read ports and a
// per-register pending-write scoreboard that flags RAW hazards to the ID stage.
module regs_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_op_c_i,
    input  logic [ADDR_W-1:0] wb_reg_waddr_i,
    input  logic              wb_reg_we_i,
    input  logic [ADDR_W-1:0] id_rs1_raddr_i,
    input  logic              id_rs1_re_i,
    input  logic [ADDR_W-1:0] id_rs2_raddr_i,
    input  logic              id_rs2_re_i,
    input  logic              id_issue_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    input  logic              id_rd_we_i,
    output logic [DATA_W-1:0] regs_rs1_rdata_o,
    output logic [DATA_W-1:0] regs_rs2_rdata_o,
    output logic              regs_stall_o,
    output logic              regs_sb_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d  [NUM_REGS];
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] inc, dec, busy;
    logic                wr_en;

    assign wr_en = wb_reg_we_i && (wb_reg_waddr_i != '0);

    // Per-register issue/retire strobes; x0 never tracks anything.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r] = id_issue_i && id_rd_we_i && (id_rd_addr_i == ADDR_W'(r));
            dec[r] = wb_reg_we_i && (wb_reg_waddr_i == ADDR_W'(r));
        end
    end

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        err_d    = err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !dec[r]) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec[r] && !inc[r]) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // A write landing this cycle resolves one pending write before the hazard test.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] - CNT_W'(dec[r])) != '0;
        end
    end

    // NOTE: the register array is reset because software relies on every register reading 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[wb_reg_waddr_i] <= wb_op_c_i;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        if (addr == '0)                                     return '0;
        else if (wb_reg_we_i && (wb_reg_waddr_i == addr))   return wb_op_c_i;
        else                                                return stored;
    endfunction

    assign regs_rs1_rdata_o = read_port(id_rs1_raddr_i, regs_q[id_rs1_raddr_i]);
    assign regs_rs2_rdata_o = read_port(id_rs2_raddr_i, regs_q[id_rs2_raddr_i]);

    assign regs_stall_o = (id_rs1_re_i && (id_rs1_raddr_i != '0) && busy[id_rs1_raddr_i]) ||
                          (id_rs2_re_i && (id_rs2_raddr_i != '0) && busy[id_rs2_raddr_i]);

    assign regs_sb_err_o = err_q;

endmodule

// File: tb/tb_regs_scoreboard.sv
// Directed bench for regs_scoreboard: bypass, x0, RAW stall, counter limits and reset.
module tb_regs_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_op_c_i;
    logic [4:0]  wb_reg_waddr_i;
    logic        wb_reg_we_i;
    logic [4:0]  id_rs1_raddr_i;
    logic        id_rs1_re_i;
    logic [4:0]  id_rs2_raddr_i;
    logic        id_rs2_re_i;
    logic        id_issue_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    logic [31:0] regs_rs1_rdata_o;
    logic [31:0] regs_rs2_rdata_o;
    logic        regs_stall_o;
    logic        regs_sb_err_o;

    int n_vec  = 0;
    int n_miss = 0;

    regs_scoreboard dut (
        .clk              (clk),
        .rst              (rst),
        .wb_op_c_i        (wb_op_c_i),
        .wb_reg_waddr_i   (wb_reg_waddr_i),
        .wb_reg_we_i      (wb_reg_we_i),
        .id_rs1_raddr_i   (id_rs1_raddr_i),
        .id_rs1_re_i      (id_rs1_re_i),
        .id_rs2_raddr_i   (id_rs2_raddr_i),
        .id_rs2_re_i      (id_rs2_re_i),
        .id_issue_i       (id_issue_i),
        .id_rd_addr_i     (id_rd_addr_i),
        .id_rd_we_i       (id_rd_we_i),
        .regs_rs1_rdata_o (regs_rs1_rdata_o),
        .regs_rs2_rdata_o (regs_rs2_rdata_o),
        .regs_stall_o     (regs_stall_o),
        .regs_sb_err_o    (regs_sb_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_op_c_i      = '0;
        wb_reg_waddr_i = '0;
        wb_reg_we_i    = 1'b0;
        id_rs1_raddr_i = '0;
        id_rs1_re_i    = 1'b0;
        id_rs2_raddr_i = '0;
        id_rs2_re_i    = 1'b0;
        id_issue_i     = 1'b0;
        id_rd_addr_i   = '0;
        id_rd_we_i     = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        id_issue_i   = 1'b1;
        id_rd_we_i   = 1'b1;
        id_rd_addr_i = rd;
        cyc();
        id_issue_i   = 1'b0;
        id_rd_we_i   = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_reg_we_i    = 1'b1;
        wb_reg_waddr_i = a;
        wb_op_c_i      = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        id_rs1_raddr_i = 5'd5;
        repeat (2) cyc();
        check("reset_rdata", regs_rs1_rdata_o, 32'h0);
        check("reset_stall", {31'b0, regs_stall_o}, 32'h0);
        check("reset_err", {31'b0, regs_sb_err_o}, 32'h0);
        rst = 1'b0;

        // x5: issue first so the writeback is matched
        issue(5'd5);
        wb(5'd5, 32'hDEADBEEF);
        id_rs1_raddr_i = 5'd5;
        #1;
        check("x5_bypass", regs_rs1_rdata_o, 32'hDEADBEEF);
        cyc();
        wb_reg_we_i = 1'b0;
        #1;
        check("x5_storage", regs_rs1_rdata_o, 32'hDEADBEEF);

        // write to x0 is dropped
        idle();
        wb(5'd0, 32'h1234);
        id_rs1_re_i = 1'b1;
        id_rs2_re_i = 1'b1;
        #1;
        check("x0_rdata", regs_rs1_rdata_o, 32'h0);
        check("x0_stall", {31'b0, regs_stall_o}, 32'h0);
        cyc();
        wb_reg_we_i = 1'b0;
        #1;
        check("x0_after", regs_rs2_rdata_o, 32'h0);
        check("x0_err", {31'b0, regs_sb_err_o}, 32'h0);

        // RAW on x7
        idle();
        issue(5'd7);
        id_rs2_raddr_i = 5'd7;
        id_rs2_re_i    = 1'b1;
        #1;
        check("x7_stall", {31'b0, regs_stall_o}, 32'h1);
        id_rs2_re_i = 1'b0;
        #1;
        check("x7_no_re", {31'b0, regs_stall_o}, 32'h0);
        id_rs2_re_i = 1'b1;
        cyc();
        check("x7_stall_hold", {31'b0, regs_stall_o}, 32'h1);
        wb(5'd7, 32'h55);
        #1;
        check("x7_wb_stall", {31'b0, regs_stall_o}, 32'h0);
        check("x7_wb_bypass", regs_rs2_rdata_o, 32'h55);
        cyc();
        wb_reg_we_i = 1'b0;
        #1;
        check("x7_after_stall", {31'b0, regs_stall_o}, 32'h0);
        check("x7_after_data", regs_rs2_rdata_o, 32'h55);

        // three in flight on x3
        idle();
        issue(5'd3);
        issue(5'd3);
        issue(5'd3);
        id_rs1_raddr_i = 5'd3;
        id_rs1_re_i    = 1'b1;
        wb(5'd3, 32'h11);
        #1;
        check("x3_wb1_stall", {31'b0, regs_stall_o}, 32'h1);
        cyc();
        wb(5'd3, 32'h22);
        #1;
        check("x3_wb2_stall", {31'b0, regs_stall_o}, 32'h1);
        cyc();
        wb(5'd3, 32'h33);
        #1;
        check("x3_wb3_stall", {31'b0, regs_stall_o}, 32'h0);
        check("x3_wb3_data", regs_rs1_rdata_o, 32'h33);
        cyc();
        wb_reg_we_i = 1'b0;
        #1;
        check("x3_idle_stall", {31'b0, regs_stall_o}, 32'h0);
        check("x3_err", {31'b0, regs_sb_err_o}, 32'h0);

        // overflow: fourth issue with cnt at max
        idle();
        issue(5'd3);
        issue(5'd3);
        issue(5'd3);
        check("ovf_err_pre", {31'b0, regs_sb_err_o}, 32'h0);
        issue(5'd3);
        check("ovf_err", {31'b0, regs_sb_err_o}, 32'h1);
        id_rs1_raddr_i = 5'd3;
        id_rs1_re_i    = 1'b1;
        #1;
        check("ovf_cnt_held", {31'b0, regs_stall_o}, 32'h1);

        // asynchronous reset mid-run
        id_rs2_raddr_i = 5'd5;
        rst = 1'b1;
        #1;
        check("rst_rs1", regs_rs1_rdata_o, 32'h0);
        check("rst_rs2", regs_rs2_rdata_o, 32'h0);
        check("rst_stall", {31'b0, regs_stall_o}, 32'h0);
        check("rst_err", {31'b0, regs_sb_err_o}, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        check("rst_x5_after", regs_rs2_rdata_o, 32'h0);

        // underflow: unmatched write to x9
        idle();
        wb(5'd9, 32'hA5A5A5A5);
        id_rs1_raddr_i = 5'd9;
        #1;
        check("unf_bypass", regs_rs1_rdata_o, 32'hA5A5A5A5);
        cyc();
        wb_reg_we_i = 1'b0;
        id_rs1_re_i = 1'b1;
        #1;
        check("unf_err", {31'b0, regs_sb_err_o}, 32'h1);
        check("unf_data", regs_rs1_rdata_o, 32'hA5A5A5A5);
        check("unf_cnt_zero", {31'b0, regs_stall_o}, 32'h0);
        cyc();
        check("err_sticky", {31'b0, regs_sb_err_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
